// File: rtl/fifo_arb_pkg.sv
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared types and widths for the FIFO write-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int c_BURST_W = 4;
  localparam int c_BEAT_W  = 16;

endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
// ============================================================================
// Module      : rr_pick2
// Description : Combinational two-way round-robin selector with ownership mask.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       rr,
  input  logic [1:0] own_mask,
  output logic       sel,
  output logic       sel_valid
);

  logic [1:0] w_cand;

  assign w_cand    = valid & own_mask;
  assign sel_valid = |w_cand;
  // Contention goes to the preferred requester; otherwise the lone candidate.
  assign sel       = (&w_cand) ? rr : w_cand[1];

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin arbiter sharing one registered FIFO write port
//               between two valid/ready producers; FIFO_ARB_BURST_EN enables
//               burst ownership of up to MAX_BURST beats per grant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 64,
  parameter int MAX_BURST  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  input  logic [DATA_W-1:0]   req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [DATA_W-1:0]   req1_data,
  output logic                req1_ready,
  output logic                wr_en,
  output logic [DATA_W-1:0]   buf_in,
  input  logic                buf_full,
  input  logic [CNT_W-1:0]    fifo_counter,
  output logic                grant_id,
  output logic [c_BEAT_W-1:0] beats0,
  output logic [c_BEAT_W-1:0] beats1
);

  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
    $error("fifo_wr_arbiter: MAX_BURST must be in 1..15");
  end
  if (FIFO_DEPTH > (1 << CNT_W) - 1) begin : g_bad_depth
    $error("fifo_wr_arbiter: FIFO_DEPTH exceeds fifo_counter range");
  end

  logic                r_wr_en;
  logic [DATA_W-1:0]   r_buf_in;
  logic                r_grant_id;
  logic [c_BEAT_W-1:0] r_beats0;
  logic [c_BEAT_W-1:0] r_beats1;
  logic                r_rr;

  logic [CNT_W:0]      w_occ;
  logic                w_space_ok;
  logic [1:0]          w_own_mask;
  logic                w_sel;
  logic                w_sel_valid;
  logic                w_accept;

  // The write registered last edge has not reached the count yet.
  assign w_occ      = {1'b0, fifo_counter} + {{CNT_W{1'b0}}, r_wr_en};
  assign w_space_ok = !buf_full && (w_occ < (CNT_W+1)'(FIFO_DEPTH));

  rr_pick2 u_pick (
    .valid     ({req1_valid, req0_valid}),
    .rr        (r_rr),
    .own_mask  (w_own_mask),
    .sel       (w_sel),
    .sel_valid (w_sel_valid)
  );

  assign w_accept   = w_space_ok && w_sel_valid;
  assign req0_ready = w_accept && !w_sel && !rst;
  assign req1_ready = w_accept &&  w_sel && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en    <= 1'b0;
      r_buf_in   <= '0;
      r_grant_id <= 1'b0;
      r_beats0   <= '0;
      r_beats1   <= '0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_buf_in   <= w_sel ? req1_data : req0_data;
        r_grant_id <= w_sel;
        if (w_sel) r_beats1 <= r_beats1 + c_BEAT_W'(1);
        else       r_beats0 <= r_beats0 + c_BEAT_W'(1);
      end
    end
  end

`ifdef FIFO_ARB_BURST_EN
  localparam logic [c_BURST_W-1:0] c_RUN_LAST = c_BURST_W'(MAX_BURST - 1);

  arb_state_t           r_state;
  arb_state_t           w_state_nxt;
  logic [c_BURST_W-1:0] r_run;
  logic [c_BURST_W-1:0] w_run_nxt;
  logic                 w_rr_nxt;

  assign w_own_mask = (r_state == OWN0) ? 2'b01 :
                      (r_state == OWN1) ? 2'b10 : 2'b11;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB;
      r_run   <= '0;
      r_rr    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
      r_rr    <= w_rr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    w_rr_nxt    = r_rr;
    case (r_state)
      ARB: begin
        if (w_accept) begin
          if (MAX_BURST == 1) begin
            w_rr_nxt = ~w_sel;
          end else begin
            w_state_nxt = w_sel ? OWN1 : OWN0;
            w_run_nxt   = c_BURST_W'(1);
          end
        end
      end
      OWN0: begin
        // A stalled owner keeps the grant; only a dropped valid releases it.
        if (!req0_valid || (w_accept && r_run == c_RUN_LAST)) begin
          w_state_nxt = ARB;
          w_run_nxt   = '0;
          w_rr_nxt    = 1'b1;
        end else if (w_accept) begin
          w_run_nxt = r_run + c_BURST_W'(1);
        end
      end
      OWN1: begin
        if (!req1_valid || (w_accept && r_run == c_RUN_LAST)) begin
          w_state_nxt = ARB;
          w_run_nxt   = '0;
          w_rr_nxt    = 1'b0;
        end else if (w_accept) begin
          w_run_nxt = r_run + c_BURST_W'(1);
        end
      end
      default: begin
        w_state_nxt = ARB;
        w_run_nxt   = '0;
      end
    endcase
  end
`else
  assign w_own_mask = 2'b11;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_rr <= 1'b0;
    else if (w_accept) r_rr <= ~r_rr;
  end
`endif

  assign wr_en    = r_wr_en;
  assign buf_in   = r_buf_in;
  assign grant_id = r_grant_id;
  assign beats0   = r_beats0;
  assign beats1   = r_beats1;

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Scoreboard bench for fifo_wr_arbiter (both burst builds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;

  localparam int DW    = 8;
  localparam int CW    = 8;
  localparam int DEPTH = 64;
  localparam int MB    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          wr_en;
  logic [DW-1:0] buf_in;
  logic          buf_full;
  logic [CW-1:0] fifo_counter;
  logic          grant_id;
  logic [15:0]   beats0, beats1;

  fifo_wr_arbiter #(
    .DATA_W(DW), .CNT_W(CW), .FIFO_DEPTH(DEPTH), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .wr_en(wr_en), .buf_in(buf_in), .buf_full(buf_full),
    .fifo_counter(fifo_counter), .grant_id(grant_id),
    .beats0(beats0), .beats1(beats1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
  } beat_t;

  beat_t         sb[$];
  logic [DW-1:0] out_log[$];
  int            n_checks = 0;
  int            n_errors = 0;

  logic          m_rr, m_wr_en;
  int            m_state, m_run;
  logic [15:0]   m_b0, m_b1;
  logic          a0, a1;
  logic [DW-1:0] t1_data [3] = '{8'd100, 8'd150, 8'd175};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference arbiter evaluated mid-cycle, while inputs are stable.
  always @(negedge clk) begin
    logic       sp, v0, v1, s, e0, e1;
    logic [1:0] mask;
    beat_t      b;
    if (rst) begin
      m_rr = 1'b0; m_wr_en = 1'b0; m_state = 0; m_run = 0; m_b0 = '0; m_b1 = '0;
      sb.delete();
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_wr_en", wr_en, 0);
    end else begin
      chk("wr_en", wr_en, m_wr_en);
      if (wr_en) begin
        if (sb.size() > 0) begin
          b = sb.pop_front();
          chk("buf_in", buf_in, b.data);
          chk("grant_id", grant_id, b.id);
          out_log.push_back(buf_in);
        end else begin
          chk("spurious_wr", wr_en, 0);
        end
      end else begin
        sb.delete();
      end
      chk("beats0", beats0, m_b0);
      chk("beats1", beats1, m_b1);

      sp   = !buf_full && ((int'(fifo_counter) + int'(m_wr_en)) < DEPTH);
      mask = 2'b11;
`ifdef FIFO_ARB_BURST_EN
      if (m_state == 1) mask = 2'b01;
      else if (m_state == 2) mask = 2'b10;
`endif
      v0 = req0_valid & mask[0];
      v1 = req1_valid & mask[1];
      s  = (v0 && v1) ? m_rr : v1;
      e0 = sp && v0 && !s;
      e1 = sp && v1 && s;
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
      m_wr_en = e0 || e1;
      if (e0) begin sb.push_back('{1'b0, req0_data}); m_b0 = m_b0 + 16'd1; end
      if (e1) begin sb.push_back('{1'b1, req1_data}); m_b1 = m_b1 + 16'd1; end
`ifdef FIFO_ARB_BURST_EN
      case (m_state)
        0: if (m_wr_en) begin
             if (MB == 1) m_rr = !s;
             else begin m_state = s ? 2 : 1; m_run = 1; end
           end
        1: if (!req0_valid) begin m_state = 0; m_rr = 1'b1; m_run = 0; end
           else if (e0) begin
             m_run++;
             if (m_run == MB) begin m_state = 0; m_rr = 1'b1; m_run = 0; end
           end
        default: if (!req1_valid) begin m_state = 0; m_rr = 1'b0; m_run = 0; end
           else if (e1) begin
             m_run++;
             if (m_run == MB) begin m_state = 0; m_rr = 1'b0; m_run = 0; end
           end
      endcase
`else
      if (m_wr_en) m_rr = !m_rr;
`endif
    end
  end

  task automatic wait_rdy(input logic which);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(which ? req1_ready : req0_ready) && n < 50);
    chk("wait_ready", which ? req1_ready : req0_ready, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] exp;
    int            blk;
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0; buf_full = 1'b0; fifo_counter = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_buf_in", buf_in, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_beats0", beats0, 0);
    chk("rst_beats1", beats1, 0);
    rst = 1'b0;

    // Single producer, three back-to-back beats.
    req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req0_data = t1_data[i];
      wait_rdy(1'b0);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t1_beats0", beats0, 3);
    chk("t1_count", out_log.size(), 3);
    for (int i = 0; i < 3 && i < out_log.size(); i++) chk("t1_data", out_log[i], t1_data[i]);

    // Both producers streaming continuously.
    do_reset();
    out_log.delete();
    req0_data = 8'hA0; req1_data = 8'hB0; req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (16) begin
      @(negedge clk);
      a0 = req0_ready; a1 = req1_ready;
      @(posedge clk); #1;
      if (a0) req0_data = req0_data + 8'd1;
      if (a1) req1_data = req1_data + 8'd1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t3_count", out_log.size(), 16);
    for (int i = 0; i < 16 && i < out_log.size(); i++) begin
`ifdef FIFO_ARB_BURST_EN
      blk = i / MB;
      exp = ((blk % 2 == 0) ? 8'hA0 : 8'hB0) + 8'((blk / 2) * MB + i % MB);
`else
      blk = i / 2;
      exp = ((i % 2 == 0) ? 8'hA0 : 8'hB0) + 8'(blk);
`endif
      chk("t3_order", out_log[i], exp);
    end

    // Occupancy boundary and full flag.
    do_reset();
    fifo_counter = 8'd63; req0_data = 8'hC0; req1_data = 8'hD0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("t4_first_accept", req0_ready, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_wr_en", wr_en, 1);
    chk("t4_edge_r0", req0_ready, 0);
    chk("t4_edge_r1", req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; fifo_counter = 8'd62;
    @(negedge clk);
    chk("t4_wr_idle", wr_en, 0);
    @(posedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 8'hC1;
    @(negedge clk);
    chk("t4_one_accept", int'(req0_ready) + int'(req1_ready), 1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    fifo_counter = 8'd0; buf_full = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("t4_full_r0", req0_ready, 0);
      chk("t4_full_r1", req1_ready, 0);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; buf_full = 1'b0;

    // Reset in the middle of a req1 run.
    do_reset();
    req1_valid = 1'b1; req1_data = 8'hE0;
    repeat (3) begin
      @(negedge clk);
      a1 = req1_ready;
      @(posedge clk); #1;
      if (a1) req1_data = req1_data + 8'd1;
    end
    chk("t5_wr_before", wr_en, 1);
    rst = 1'b1;
    #1;
    chk("t5_wr_en", wr_en, 0);
    chk("t5_beats1", beats1, 0);
    chk("t5_grant_rst", grant_id, 0);
    chk("t5_buf_in", buf_in, 0);
    chk("t5_ready1", req1_ready, 0);
    req0_valid = 1'b1; req0_data = 8'h55;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_first_r0", req0_ready, 1);
    chk("t5_first_r1", req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t5_grant", grant_id, 0);
    chk("t5_beats0", beats0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
